reaction_timer: RTL



---
 rtl/f1_pkg.sv | 16 +
 rtl/key_sync_edge.sv | 38 +++
 rtl/reaction_timer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types and constants for the start-light blocks
// Purpose: millisecond result width, default saturation value and the
//          reaction timer state encoding.
package f1_pkg;

  localparam int MS_W = 14;
  localparam logic [MS_W-1:0] MS_MAX = 14'd9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    TIMING = 2'd2,
    DONE   = 2'd3
  } react_state_t;

endpackage

// File: rtl/key_sync_edge.sv
// rtl/key_sync_edge.sv - two-flop synchronizer plus registered rising-edge pulse
// Purpose: bring an asynchronous button level into the clk domain and emit a
//          single-cycle pulse per press, however long the button is held.
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset
//   key_i   in  asynchronous button level, active-high
//   press_o out one-cycle registered pulse, three edges after key_i rises
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic press_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      // Registered so downstream logic never sees a combinational path
      press_q <= sync2_q & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - lights-out to button-press reaction timer in ms
// Purpose: counts tick_ms pulses from lights_out to the first synchronized
//          button press; flags jump starts and timeouts. Optional best-time
//          tracking is enabled by defining REACT_BEST_EN.
// Ports:
//   clk, rst_n  in  clock, synchronous active-low reset
//   tick_ms     in  one-cycle pulse per millisecond
//   arm         in  one-cycle pulse: start (or restart) a measurement
//   lights_out  in  one-cycle pulse: start timing
//   key_press   in  asynchronous button level, active-high
//   react_ms    out captured reaction time (MAX_MS on timeout, 0 on jump start)
//   valid       out fresh valid result held
//   jump_start  out press seen before lights out
//   timeout     out no press within MAX_MS ms
//   best_ms     out lowest valid time since reset (REACT_BEST_EN only)
module reaction_timer
  import f1_pkg::*;
#(
  parameter logic [MS_W-1:0] MAX_MS = MS_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_ms,
  input  logic            arm,
  input  logic            lights_out,
  input  logic            key_press,
  output logic [MS_W-1:0] react_ms,
  output logic            valid,
  output logic            jump_start,
  output logic            timeout
`ifdef REACT_BEST_EN
  ,
  output logic [MS_W-1:0] best_ms
`endif
);

  logic press;

  key_sync_edge u_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_i   (key_press),
    .press_o (press)
  );

  react_state_t    state_q, state_d;
  logic [MS_W-1:0] cnt_q, cnt_d;
  logic [MS_W-1:0] react_q, react_d;
  logic            valid_q, valid_d;
  logic            jump_q, jump_d;
  logic            timeout_q, timeout_d;
  logic [MS_W-1:0] cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      react_q   <= '0;
      valid_q   <= 1'b0;
      jump_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      react_q   <= react_d;
      valid_q   <= valid_d;
      jump_q    <= jump_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    react_d   = react_q;
    valid_d   = valid_q;
    jump_d    = jump_q;
    timeout_d = timeout_q;
    cnt_inc   = cnt_q + 14'd1;

    if (arm) begin
      // Restart from any state, including mid-measurement
      state_d   = ARMED;
      cnt_d     = '0;
      react_d   = '0;
      valid_d   = 1'b0;
      jump_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ARMED: begin
          // A press coinciding with lights_out is still a jump start
          if (press) begin
            state_d = DONE;
            jump_d  = 1'b1;
            react_d = '0;
          end else if (lights_out) begin
            state_d = TIMING;
            cnt_d   = '0;
          end
        end
        TIMING: begin
          // Press beats a simultaneous tick: that tick is not counted
          if (press) begin
            state_d = DONE;
            react_d = cnt_q;
            valid_d = 1'b1;
          end else if (tick_ms) begin
            if (cnt_inc >= MAX_MS) begin
              state_d   = DONE;
              cnt_d     = MAX_MS;
              react_d   = MAX_MS;
              timeout_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign react_ms   = react_q;
  assign valid      = valid_q;
  assign jump_start = jump_q;
  assign timeout    = timeout_q;

`ifdef REACT_BEST_EN
  logic [MS_W-1:0] best_q, best_d;
  logic            capture;

  assign capture = !arm && (state_q == TIMING) && press;

  always_comb begin
    best_d = best_q;
    if (capture && (cnt_q < best_q)) begin
      best_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_q <= MAX_MS;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_ms = best_q;
`endif

endmodule
